// File: rtl/rils_pkg.sv
// Shared definitions for the multi-cycle load/store/R/I datapath.
// Contents: instruction opcode and funct encodings, ALU operation encoding,
// controller state enum, fault codes and an instruction legality helper.
package rils_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSlt = 4'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [1:0] FaultNone     = 2'd0;
  localparam logic [1:0] FaultIllegal  = 2'd1;
  localparam logic [1:0] FaultMisalign = 2'd2;

  // True when the opcode (and funct, for R-type) is one the datapath executes.
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic legal;
    case (opcode)
      OpRtype: legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                       (funct == FnOr)  || (funct == FnSlt);
      OpLw, OpSw, OpBeq, OpAddi, OpAndi, OpOri: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rils_alu_n.sv
// N-bit combinational ALU for the multi-cycle datapath.
// Ports:
//   a_i, b_i   operands
//   op_i       operation select (add, sub, and, or, signed set-less-than)
//   result_o   operation result; add/sub wrap modulo 2^N
//   zero_o     high when result_o is all zeros
module rils_alu_n
  import rils_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] result_o,
  output logic         zero_o
);

  logic slt;

  always_comb begin
    slt = $signed(a_i) < $signed(b_i);
    result_o = '0;
    unique case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluSlt:  result_o = {{(N-1){1'b0}}, slt};
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/multicycle_rils_datapath.sv
// Multi-cycle datapath executing lw, sw, beq, addi, andi, ori and R-type
// add/sub/and/or/slt over a single shared memory port with a req/ack handshake.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mem_req/we/addr/wdata  unified memory request bus (decoded from state)
//   mem_rdata, mem_ack  memory response; a transfer completes on req && ack
//   pc                  current program counter
//   retire              one-cycle pulse per completed instruction
//   halted, fault_code  sticky fault indication (1 illegal, 2 misaligned)
//   dbg_raddr/dbg_rdata combinational register-file debug read
module multicycle_rils_datapath
  import rils_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter int unsigned  NUM_REGS = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  localparam int unsigned RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic [N-1:0]  pc,
  output logic          retire,
  output logic          halted,
  output logic [1:0]    fault_code,
  input  logic [RW-1:0] dbg_raddr,
  output logic [N-1:0]  dbg_rdata
);

  // Architectural and microarchitectural state
  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [31:0]    ir_q, ir_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   alu_q, alu_d;
  logic [N-1:0]   mdr_q, mdr_d;
  logic           retire_q, retire_d;
  logic           halted_q, halted_d;
  logic [1:0]     fault_q, fault_d;
  logic [N-1:0]   regs_q [NUM_REGS];
  logic [N-1:0]   regs_d [NUM_REGS];

  // Instruction fields
  logic [5:0]     opcode;
  logic [5:0]     funct;
  logic [RW-1:0]  rs_idx, rt_idx, rd_idx, wb_idx;
  logic [15:0]    imm16;
  logic [N-1:0]   sext_imm, zext_imm;
  logic           is_rtype, is_lw, is_sw, is_beq, is_andi, is_ori;

  // ALU interface
  alu_op_e        alu_op;
  logic [N-1:0]   alu_b;
  logic [N-1:0]   alu_result;
  logic           alu_zero;

  logic [N-1:0]   branch_target;
  logic [N-1:0]   wb_data;

  always_comb begin
    opcode   = ir_q[31:26];
    funct    = ir_q[5:0];
    rs_idx   = ir_q[21 +: RW];
    rt_idx   = ir_q[16 +: RW];
    rd_idx   = ir_q[11 +: RW];
    imm16    = ir_q[15:0];
    sext_imm = N'($signed(imm16));
    zext_imm = N'(imm16);
    is_rtype = (opcode == OpRtype);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_andi  = (opcode == OpAndi);
    is_ori   = (opcode == OpOri);
    wb_idx   = is_rtype ? rd_idx : rt_idx;
    wb_data  = is_lw ? mdr_q : alu_q;
    // pc already points past the branch by the time the target is used
    branch_target = pc_q + (sext_imm << 2);
  end

  // ALU operation and second-operand select
  always_comb begin
    alu_op = AluAdd;
    alu_b  = sext_imm;
    if (is_rtype) begin
      alu_b = b_q;
      unique case (funct)
        FnSub:   alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnSlt:   alu_op = AluSlt;
        default: alu_op = AluAdd;
      endcase
    end else if (is_beq) begin
      alu_op = AluSub;
      alu_b  = b_q;
    end else if (is_andi) begin
      alu_op = AluAnd;
      alu_b  = zext_imm;
    end else if (is_ori) begin
      alu_op = AluOr;
      alu_b  = zext_imm;
    end
  end

  rils_alu_n #(
    .N (N)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Controller next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;

    unique case (state_q)
      StFetch: begin
        if (mem_ack) begin
          ir_d    = 32'(mem_rdata);
          pc_d    = pc_q + N'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = regs_q[rs_idx];
        b_d = regs_q[rt_idx];
        if (!is_legal(opcode, funct)) begin
          fault_d  = FaultIllegal;
          halted_d = 1'b1;
          state_d  = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_d = alu_result;
        if (is_beq) begin
          if (alu_zero) pc_d = branch_target;
          retire_d = 1'b1;
          state_d  = StFetch;
        end else if (is_lw || is_sw) begin
          if (alu_result[1:0] != 2'b00) begin
            fault_d  = FaultMisalign;
            halted_d = 1'b1;
            state_d  = StHalt;
          end else begin
            state_d = StMem;
          end
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ack) begin
          if (is_sw) begin
            retire_d = 1'b1;
            state_d  = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        retire_d = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  // Register file write port; index 0 is never written so it always reads 0
  always_comb begin
    regs_d = regs_q;
    if ((state_q == StWb) && (wb_idx != '0)) begin
      regs_d[wb_idx] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= FaultNone;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      regs_q   <= regs_d;
    end
  end

  // Memory bus decodes straight from state; reset masks any request so an
  // ack seen during reset cannot complete a transfer.
  always_comb begin
    mem_req   = ((state_q == StFetch) || (state_q == StMem)) && !rst;
    mem_we    = (state_q == StMem) && is_sw && !rst;
    mem_addr  = (state_q == StMem) ? alu_q : pc_q;
    mem_wdata = b_q;
  end

  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign fault_code = fault_q;
  assign dbg_rdata  = regs_q[dbg_raddr];

endmodule

// File: tb/tb_multicycle_rils_datapath.sv
// Directed, table-driven bench for multicycle_rils_datapath with a
// behavioural unified memory that inserts a programmable number of wait states.
module tb_multicycle_rils_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc;
  logic        retire, halted;
  logic [1:0]  fault_code;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  always #5 clk = ~clk;

  multicycle_rils_datapath #(
    .N        (32),
    .NUM_REGS (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .retire     (retire),
    .halted     (halted),
    .fault_code (fault_code),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [64];
  int          waits;
  logic        ack_force;
  int          wcnt, acc_cnt, cur_len, run_n, wr_cnt;
  int          run_len [16];
  logic [31:0] wr_addr, wr_data;
  int          cyc = 0;

  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ack   = ack_force | (mem_req && (wcnt == waits));

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0; acc_cnt <= 0; cur_len <= 0; run_n <= 0; wr_cnt <= 0;
    end else if (mem_req) begin
      if (mem_ack) begin
        wcnt    <= 0;
        acc_cnt <= acc_cnt + 1;
        if (run_n < 16) run_len[run_n] <= cur_len + 1;
        run_n   <= run_n + 1;
        cur_len <= 0;
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          wr_cnt  <= wr_cnt + 1;
          wr_addr <= mem_addr;
          wr_data <= mem_wdata;
        end
      end else begin
        wcnt    <= wcnt + 1;
        cur_len <= cur_len + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_retire(input string name, output int at);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (retire) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout_fail(name);
  endtask

  task automatic wait_halt(input string name);
    bit seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted) begin
        seen = 1;
        break;
      end
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    ack_force = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [31:0] val);
    dbg_raddr = 5'(idx);
    #1;
    val = dbg_rdata;
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] next_fetch;
  } beq_vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND = 6'b100100;
  localparam logic [5:0] OR = 6'b100101, SLT = 6'b101010;

  alu_vec_t    tv [14];
  beq_vec_t    bv [2];
  logic [31:0] v;
  int          t0, t1, t2, t3, prev, now, cnt;

  initial begin
    rst = 1'b1; ack_force = 1'b0; waits = 0; dbg_raddr = '0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;

    tv[0]  = '{enc_i(ADDI, 0, 1, 20),      1,  32'd20};
    tv[1]  = '{enc_i(ADDI, 0, 2, -1),      2,  32'hFFFF_FFFF};
    tv[2]  = '{enc_r(1, 2, 3, ADD),        3,  32'd19};
    tv[3]  = '{enc_r(1, 2, 4, SUB),        4,  32'd21};
    tv[4]  = '{enc_r(2, 1, 5, SLT),        5,  32'd1};
    tv[5]  = '{enc_r(1, 2, 6, SLT),        6,  32'd0};
    tv[6]  = '{enc_i(ANDI, 2, 7, 16'hF0F0), 7, 32'h0000_F0F0};
    tv[7]  = '{enc_i(ORI, 0, 8, 16'h8001), 8,  32'h0000_8001};
    tv[8]  = '{enc_r(2, 1, 9, AND),        9,  32'd20};
    tv[9]  = '{enc_r(1, 4, 10, OR),        10, 32'd21};
    tv[10] = '{enc_i(ADDI, 0, 0, 5),       0,  32'd0};
    tv[11] = '{enc_i(ADDI, 1, 11, -24),    11, 32'hFFFF_FFFC};
    tv[12] = '{enc_r(0, 2, 12, SUB),       12, 32'd1};
    tv[13] = '{enc_r(11, 5, 13, SLT),      13, 32'd1};

    bv[0] = '{enc_i(BEQ, 1, 1, 2), 32'h1C};
    bv[1] = '{enc_i(BEQ, 1, 2, 2), 32'h14};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset pc", pc, 32'h0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset retire", 32'(retire), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset fault_code", 32'(fault_code), 32'd0);
    read_reg(5, v);
    check("reset r5", v, 32'h0);

    // ---- ALU table, zero-wait memory ----
    for (int i = 0; i < 14; i++) mem[i] = tv[i].instr;
    waits = 0;
    release_reset();
    #1;
    check("first fetch addr", mem_addr, 32'h0);
    check("first fetch req", 32'(mem_req), 32'd1);
    prev = -1;
    for (int i = 0; i < 14; i++) begin
      wait_retire($sformatf("alu%0d retire", i), now);
      if (i > 0 && now >= 0 && prev >= 0)
        check($sformatf("alu%0d spacing", i), 32'(now - prev), 32'd4);
      read_reg(tv[i].rd, v);
      check($sformatf("alu%0d r%0d", i, tv[i].rd), v, tv[i].exp);
      prev = now;
    end

    // ---- sw/lw with 3 wait states (program placed at 0x40 via beq) ----
    hold_reset();
    mem[0]  = enc_i(BEQ, 0, 0, 15);
    mem[16] = enc_i(ADDI, 0, 1, 20);
    mem[17] = enc_i(SW, 0, 1, 8);
    mem[18] = enc_i(LW, 0, 6, 8);
    waits = 3;
    release_reset();
    wait_retire("ls beq retire", t0);
    wait_retire("ls addi retire", t1);
    wait_retire("ls sw retire", t2);
    check("ls sw write count", 32'(wr_cnt), 32'd1);
    check("ls sw write addr", wr_addr, 32'd8);
    check("ls sw write data", wr_data, 32'd20);
    wait_retire("ls lw retire", t3);
    check("ls addi latency", 32'(t1 - t0), 32'd7);
    check("ls sw latency", 32'(t2 - t1), 32'd10);
    check("ls lw latency", 32'(t3 - t2), 32'd11);
    read_reg(6, v);
    check("ls r6", v, 32'd20);
    check("ls mem[8]", mem[2], 32'd20);
    check("ls access count", 32'(run_n), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("ls req cycles %0d", k), 32'(run_len[k]), 32'd4);

    // ---- beq taken / not taken at pc 0x10 ----
    for (int i = 0; i < 2; i++) begin
      hold_reset();
      mem[0] = enc_i(ADDI, 0, 1, 7);
      mem[1] = enc_i(ADDI, 0, 2, 9);
      mem[2] = enc_i(ADDI, 0, 3, 1);
      mem[3] = enc_i(ADDI, 0, 4, 2);
      mem[4] = bv[i].instr;
      waits = 0;
      release_reset();
      for (int k = 0; k < 4; k++) wait_retire($sformatf("beq%0d pre %0d", i, k), prev);
      wait_retire($sformatf("beq%0d retire", i), now);
      check($sformatf("beq%0d latency", i), 32'(now - prev), 32'd3);
      check($sformatf("beq%0d next fetch", i), mem_addr, bv[i].next_fetch);
      check($sformatf("beq%0d pc", i), pc, bv[i].next_fetch);
    end

    // ---- illegal opcode ----
    hold_reset();
    mem[0] = enc_i(ADDI, 0, 1, 3);
    mem[1] = 32'hFC00_0000;
    waits = 0;
    release_reset();
    wait_halt("illegal halt");
    check("illegal halted", 32'(halted), 32'd1);
    check("illegal fault_code", 32'(fault_code), 32'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("illegal req while halted", 32'(cnt), 32'd0);
    read_reg(1, v);
    check("illegal r1", v, 32'd3);

    // ---- misaligned lw ----
    hold_reset();
    mem[0] = enc_i(ADDI, 0, 7, 9);
    mem[1] = enc_i(LW, 0, 7, 2);
    waits = 0;
    release_reset();
    wait_halt("misalign halt");
    check("misalign fault_code", 32'(fault_code), 32'd2);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("misalign req while halted", 32'(cnt), 32'd0);
    check("misalign access count", 32'(acc_cnt), 32'd2);
    read_reg(7, v);
    check("misalign r7", v, 32'd9);

    // ---- reset during an outstanding lw, with ack in the reset cycle ----
    hold_reset();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    mem[1] = enc_i(LW, 0, 6, 32);
    mem[8] = 32'h0000_ABCD;
    waits = 3;
    release_reset();
    wait_retire("rstmid addi retire", now);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'd32) begin
        cnt = 1;
        break;
      end
    end
    if (cnt == 0) timeout_fail("rstmid lw request");
    rst = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_force = 1'b0;
    #1;
    check("rstmid pc", pc, 32'h0);
    check("rstmid fetch req", 32'(mem_req), 32'd1);
    check("rstmid fetch addr", mem_addr, 32'h0);
    check("rstmid halted", 32'(halted), 32'd0);
    read_reg(6, v);
    check("rstmid r6", v, 32'd0);
    read_reg(1, v);
    check("rstmid r1", v, 32'd0);
    repeat (3) @(negedge clk);
    read_reg(6, v);
    check("rstmid r6 later", v, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
